// File: rtl/tail_light_sequencer.sv
// Thunderbird-style tail-light controller.
// Drives turn, hazard and brake patterns on Lcba/Rabc from the system clock.
// A prescaler produces one sequence step every TICK_DIV cycles, so no derived
// clocks are needed. All outputs are registered from the next state.
module tail_light_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] Lcba,
  output logic [2:0] Rabc,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    L1      = 4'd1,
    L2      = 4'd2,
    L3      = 4'd3,
    R1      = 4'd4,
    R2      = 4'd5,
    R3      = 4'd6,
    PAUSE   = 4'd7,
    HAZ_ON  = 4'd8,
    HAZ_OFF = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lcba_q, lcba_d;
  logic [2:0]       rabc_q, rabc_d;
  logic             busy_q, busy_d;

  req_t             req_s;
  state_t           decide_s;
  logic             step_s;

  // Request decode: hazard (or both turn signals) wins over a single direction.
  always_comb begin
    req_s = REQ_NONE;
    if (hazard || (left && right)) begin
      req_s = REQ_HAZ;
    end else if (left) begin
      req_s = REQ_LEFT;
    end else if (right) begin
      req_s = REQ_RIGHT;
    end else begin
      req_s = REQ_NONE;
    end
  end

  // Destination chosen at a decision point (IDLE, end of PAUSE, end of HAZ_OFF).
  always_comb begin
    decide_s = IDLE;
    case (req_s)
      REQ_HAZ:   decide_s = HAZ_ON;
      REQ_LEFT:  decide_s = L1;
      REQ_RIGHT: decide_s = R1;
      REQ_NONE:  decide_s = IDLE;
      default:   decide_s = IDLE;
    endcase
  end

  // Step strobe: last cycle of a non-IDLE state.
  always_comb begin
    step_s = 1'b0;
    if ((state_q != IDLE) && (cnt_q == CNT_LAST)) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  // Prescaler: parked at zero in IDLE, so every state entered lasts TICK_DIV cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = CNT_ZERO;
    end else if (step_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Next-state logic; turn sequences only yield to hazard, never to a direction change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = decide_s;
      L1: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : L2;
        end else begin
          state_d = L1;
        end
      end
      L2: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : L3;
        end else begin
          state_d = L2;
        end
      end
      L3: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : PAUSE;
        end else begin
          state_d = L3;
        end
      end
      R1: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : R2;
        end else begin
          state_d = R1;
        end
      end
      R2: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : R3;
        end else begin
          state_d = R2;
        end
      end
      R3: begin
        if (step_s) begin
          state_d = (req_s == REQ_HAZ) ? HAZ_ON : PAUSE;
        end else begin
          state_d = R3;
        end
      end
      PAUSE: begin
        if (step_s) begin
          state_d = decide_s;
        end else begin
          state_d = PAUSE;
        end
      end
      HAZ_ON: begin
        if (step_s) begin
          state_d = HAZ_OFF;
        end else begin
          state_d = HAZ_ON;
        end
      end
      HAZ_OFF: begin
        if (step_s) begin
          state_d = decide_s;
        end else begin
          state_d = HAZ_OFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lamp patterns from the next state; brake fills any side not running a turn.
  always_comb begin
    lcba_d = {3{brake}};
    rabc_d = {3{brake}};
    case (state_d)
      L1:      lcba_d = 3'b001;
      L2:      lcba_d = 3'b011;
      L3:      lcba_d = 3'b111;
      R1:      rabc_d = 3'b100;
      R2:      rabc_d = 3'b110;
      R3:      rabc_d = 3'b111;
      HAZ_ON: begin
        lcba_d = 3'b111;
        rabc_d = 3'b111;
      end
      HAZ_OFF: begin
        lcba_d = 3'b000;
        rabc_d = 3'b000;
      end
      IDLE, PAUSE: begin
        lcba_d = {3{brake}};
        rabc_d = {3{brake}};
      end
      default: begin
        lcba_d = 3'b000;
        rabc_d = 3'b000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, prescaler and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      lcba_q  <= 3'b000;
      rabc_q  <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcba_q  <= lcba_d;
      rabc_q  <= rabc_d;
      busy_q  <= busy_d;
    end
  end

  assign Lcba = lcba_q;
  assign Rabc = rabc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer.
// The driver applies directed vectors on the falling edge and queues the
// hand-computed lamp/busy values expected after the next rising edge; a
// separate monitor pops one entry per rising edge and compares.
module tb_tail_light_sequencer;

  logic       clk;
  logic       reset, left, right, hazard, brake;
  logic [2:0] lcba, rabc;
  logic       busy;

  logic       reset1, left1;
  logic [2:0] lcba1, rabc1;
  logic       busy1;

  typedef struct {
    bit         sel;   // 0: TICK_DIV=4 instance, 1: TICK_DIV=1 instance
    logic [2:0] l;
    logic [2:0] r;
    logic       b;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  tail_light_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake), .Lcba(lcba), .Rabc(rabc), .busy(busy)
  );

  tail_light_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset1), .left(left1), .right(1'b0),
    .hazard(1'b0), .brake(1'b0), .Lcba(lcba1), .Rabc(rabc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n cycles of one input combination on the main instance.
  task automatic apply(input string tag, input logic rst, input logic l, input logic r,
                       input logic h, input logic b, input logic [2:0] el,
                       input logic [2:0] er, input logic eb, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = rst; left = l; right = r; hazard = h; brake = b;
      e.sel = 1'b0; e.l = el; e.r = er; e.b = eb; e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  // Drive one cycle on the TICK_DIV=1 instance.
  task automatic apply1(input string tag, input logic rst, input logic l,
                        input logic [2:0] el, input logic eb);
    exp_t e;
    @(negedge clk);
    reset1 = rst; left1 = l;
    e.sel = 1'b1; e.l = el; e.r = 3'b000; e.b = eb; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the queued expectation after each rising edge.
  initial begin
    exp_t       e;
    logic [6:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got  = e.sel ? {lcba1, rabc1, busy1} : {lcba, rabc, busy};
        want = {e.l, e.r, e.b};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL %s: got Lcba=%b Rabc=%b busy=%b, want Lcba=%b Rabc=%b busy=%b",
                   e.tag, got[6:4], got[3:1], got[0], want[6:4], want[3:1], want[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    reset1 = 1'b1; left1 = 1'b0;

    // Reset state
    apply("reset", 1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 2);

    // Continuous left: two full periods
    for (int p = 0; p < 2; p++) begin
      apply("left_L1",    0, 1, 0, 0, 0, 3'b001, 3'b000, 1, 4);
      apply("left_L2",    0, 1, 0, 0, 0, 3'b011, 3'b000, 1, 4);
      apply("left_L3",    0, 1, 0, 0, 0, 3'b111, 3'b000, 1, 4);
      apply("left_PAUSE", 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    end
    apply("reset2", 1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);

    // Right pulse for one cycle runs to completion then idles
    apply("right_R1a",   0, 0, 1, 0, 0, 3'b000, 3'b100, 1, 1);
    apply("right_R1",    0, 0, 0, 0, 0, 3'b000, 3'b100, 1, 3);
    apply("right_R2",    0, 0, 0, 0, 0, 3'b000, 3'b110, 1, 4);
    apply("right_R3",    0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 4);
    apply("right_PAUSE", 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    apply("right_IDLE",  0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 2);

    // Brake with left, left released mid-L2
    apply("brk_L1",    0, 1, 0, 0, 1, 3'b001, 3'b111, 1, 4);
    apply("brk_L2a",   0, 1, 0, 0, 1, 3'b011, 3'b111, 1, 2);
    apply("brk_L2b",   0, 0, 0, 0, 1, 3'b011, 3'b111, 1, 2);
    apply("brk_L3",    0, 0, 0, 0, 1, 3'b111, 3'b111, 1, 4);
    apply("brk_PAUSE", 0, 0, 0, 0, 1, 3'b111, 3'b111, 1, 4);
    apply("brk_IDLE",  0, 0, 0, 0, 1, 3'b111, 3'b111, 0, 2);
    apply("brk_off",   0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);

    // Hazard during R1, brake ignored, left&right equivalent to hazard
    apply("haz_R1a",    0, 0, 1, 0, 0, 3'b000, 3'b100, 1, 1);
    apply("haz_R1",     0, 0, 0, 1, 0, 3'b000, 3'b100, 1, 3);
    apply("haz_on1",    0, 0, 0, 1, 0, 3'b111, 3'b111, 1, 4);
    apply("haz_off1",   0, 0, 0, 1, 1, 3'b000, 3'b000, 1, 4);
    apply("haz_on2",    0, 0, 0, 1, 1, 3'b111, 3'b111, 1, 4);
    apply("lr_off",     0, 1, 1, 0, 0, 3'b000, 3'b000, 1, 4);
    apply("lr_on",      0, 1, 1, 0, 0, 3'b111, 3'b111, 1, 4);
    apply("haz_off3",   0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    apply("haz_IDLE",   0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 2);

    // Reset mid-L3 with left still high
    apply("rst_L1",     0, 1, 0, 0, 0, 3'b001, 3'b000, 1, 4);
    apply("rst_L2",     0, 1, 0, 0, 0, 3'b011, 3'b000, 1, 4);
    apply("rst_L3",     0, 1, 0, 0, 0, 3'b111, 3'b000, 1, 2);
    apply("rst_mid",    1, 1, 0, 0, 0, 3'b000, 3'b000, 0, 1);
    apply("rst_relL1",  0, 1, 0, 0, 0, 3'b001, 3'b000, 1, 2);
    apply("rst_end",    1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);

    // TICK_DIV=1 instance: one state per clock
    apply1("t1_reset", 1, 0, 3'b000, 0);
    for (int p = 0; p < 2; p++) begin
      apply1("t1_L1",    0, 1, 3'b001, 1);
      apply1("t1_L2",    0, 1, 3'b011, 1);
      apply1("t1_L3",    0, 1, 3'b111, 1);
      apply1("t1_PAUSE", 0, 1, 3'b000, 1);
    end
    apply1("t1_IDLE", 0, 0, 3'b000, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
- Controller FSM that generates the Thunderbird-style turn, hazard and brake patterns on Lcba[2:0] and Rabc[2:0].
- Its outputs drive the tail-light dimmer stage, which applies dim or full brightness per lamp.
- Contains a step-rate prescaler, so sequencing runs from the system clock with no derived clocks.

Parameters:
- TICK_DIV, 4, clock cycles per sequence step. Legal range 1..2^24; silicon builds override it, for example 12_500_000 for 4 Hz at 50 MHz.
- CNT_W, $clog2(TICK_DIV) (minimum 1), prescaler counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- left  input  1  left turn request, level, synchronous to clk.
- right  input  1  right turn request, level.
- hazard  input  1  hazard request, level.
- brake  input  1  brake pedal, level.
- Lcba  output  3  left lamps {Lc,Lb,La}, registered, 1 = lamp on.
- Rabc  output  3  right lamps {Ra,Rb,Rc}, registered, 1 = lamp on.
- busy  output  1  registered; 1 whenever state != IDLE.

Behaviour:
- Reset is sampled on the clk edge: state=IDLE, cnt=0, Lcba=000, Rabc=000, busy=0. Reset has priority over all inputs, including mid-sequence; the next cycle is IDLE with all lamps off.
- States: IDLE, L1, L2, L3, R1, R2, R3, PAUSE, HAZ_ON, HAZ_OFF.
- Request decode, evaluated when a decision is taken:
  - HAZ if hazard=1 or (left=1 and right=1).
  - else LEFT if left=1.
  - else RIGHT if right=1.
  - else NONE.
- Prescaler:
  - In IDLE, cnt holds 0.
  - In all other states, cnt increments each cycle.
  - step=1 when cnt==TICK_DIV-1; on step, cnt returns to 0.
  - Leaving IDLE loads cnt=0, so every non-IDLE state lasts exactly TICK_DIV cycles.
- IDLE: decides every cycle. HAZ->HAZ_ON, LEFT->L1, RIGHT->R1, NONE->IDLE. Latency from request to first lamp is 1 cycle: the request is sampled at edge N and the pattern is visible after edge N.
- Turn sequences run to completion; a turn request that drops mid-sequence does not truncate it.
  - Left: L1 -> L2 -> L3 -> PAUSE, each transition on step.
  - Right: R1 -> R2 -> R3 -> PAUSE, each transition on step.
- Hazard preemption: if the decoded request is HAZ at a step inside L1..L3 or R1..R3, the FSM goes to HAZ_ON instead of the next turn state.
- Direction change mid-sequence (e.g. left drops and right rises) does not preempt; the new direction is honoured at the PAUSE decision.
- PAUSE: on step, decides HAZ->HAZ_ON, LEFT->L1, RIGHT->R1, NONE->IDLE.
  - Continuous left gives a 4*TICK_DIV period: 001, 011, 111, 000.
- HAZ_ON -> HAZ_OFF on step.
- HAZ_OFF: on step, decides as PAUSE does, so continuous hazard gives a 2*TICK_DIV period.
- Output patterns, registered from next-state and brake sampled at the same edge:
  - L1: Lcba=001. L2: Lcba=011. L3: Lcba=111. The right side shows {3{brake}}.
  - R1: Rabc=100. R2: Rabc=110. R3: Rabc=111. The left side shows {3{brake}}.
  - IDLE and PAUSE: both sides {3{brake}}.
  - HAZ_ON: both sides 111. HAZ_OFF: both sides 000. Brake is ignored during hazard.
- Brake changes appear on the outputs 1 cycle after sampling and do not affect state or cnt.
- busy = (next_state != IDLE), registered.
- TICK_DIV=1: step is asserted every non-IDLE cycle, so each state lasts 1 cycle.

Test Plan:
- Reset, then left=1 held, TICK_DIV=4 -> Lcba = 001 (4 cycles), 011 (4), 111 (4), 000 (4), repeating. Rabc=000 throughout; busy=1.
- Pulse right=1 for 1 cycle from IDLE -> Rabc = 100, 110, 111, 000, 4 cycles each, then IDLE with busy=0. Lcba=000 throughout.
- Hold brake=1 and left=1 -> Rabc=111 steady, Lcba sequences. Release left mid-L2 -> sequence finishes L3 and PAUSE, then Lcba=111 and Rabc=111 in IDLE.
- Assert hazard during R1 -> at the next step both sides 111 for 4 cycles, then 000 for 4 cycles, alternating. Brake=1 does not alter the pattern; left=right=1 without hazard gives the identical pattern.
- Assert reset mid-L3 -> next cycle Lcba=000, Rabc=000, busy=0. With left still high, L1 (001) appears 1 cycle after reset deasserts.
- TICK_DIV=1 build, left=1 -> Lcba cycles 001, 011, 111, 000 at one state per clock.
